jtag_user_dr: RTL

- Parametrised multi-channel JTAG user data-register engine in the system clock domain.
- Oversamples the raw TCK/TMS/TDI/SEL/RESET outputs of the BSCANE2 user-chain wrappers and tracks the 16-state TAP controller from TMS.
- Per channel: captures a parallel word at Capture-DR, shifts it LSB-first in Shift-DR, and emits a one-cycle update strobe with the shifted-in word at Update-DR.
- Replaces per-chain hand-built DR logic; debug-module and host-mailbox channels are clients.

---
 rtl/jtag_pkg.sv | 49 ++++
 rtl/jtag_user_dr_if.sv | 39 +++
 rtl/jtag_in_sync.sv | 31 +++
 rtl/jtag_user_dr.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state encoding, IEEE 1149.1 next-state function and channel-index width helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        case (s)
            TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         tap_next = tms ? SELECT_DR : RUN_IDLE;
            SELECT_DR:        tap_next = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       tap_next = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:         tap_next = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:         tap_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         tap_next = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:         tap_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        tap_next = tms ? SELECT_DR : RUN_IDLE;
            SELECT_IR:        tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       tap_next = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:         tap_next = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:         tap_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         tap_next = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:         tap_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        tap_next = tms ? SELECT_DR : RUN_IDLE;
            default:          tap_next = TEST_LOGIC_RESET;
        endcase
    endfunction

    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtag_user_dr_if.sv
// JTAG pin and update-bus bundle; upd_len_err exists only with JTAG_DR_LEN_CHECK_EN.
interface jtag_user_dr_if #(
    parameter int unsigned NUM_CHAN = 2,
    parameter int unsigned DR_WIDTH = 32
);
    import jtag_pkg::*;
    localparam int unsigned CHAN_W = chan_w(NUM_CHAN);

    logic                         jtag_tck;
    logic                         jtag_tms;
    logic                         jtag_tdi;
    logic                         jtag_reset;
    logic [NUM_CHAN-1:0]          jtag_sel;
    logic                         jtag_tdo;
    logic [NUM_CHAN*DR_WIDTH-1:0] cap_data;
    logic                         upd_valid;
    logic [CHAN_W-1:0]            upd_chan;
    logic [DR_WIDTH-1:0]          upd_data;
`ifdef JTAG_DR_LEN_CHECK_EN
    logic                         upd_len_err;
`endif

    modport slave (
        input  jtag_tck, jtag_tms, jtag_tdi, jtag_reset, jtag_sel, cap_data,
`ifdef JTAG_DR_LEN_CHECK_EN
        output upd_len_err,
`endif
        output jtag_tdo, upd_valid, upd_chan, upd_data
    );

    modport master (
        output jtag_tck, jtag_tms, jtag_tdi, jtag_reset, jtag_sel, cap_data,
`ifdef JTAG_DR_LEN_CHECK_EN
        input  upd_len_err,
`endif
        input  jtag_tdo, upd_valid, upd_chan, upd_data
    );

endinterface

// File: rtl/jtag_in_sync.sv
// Multi-flop synchroniser for a bus of asynchronous inputs with rise/fall detect on the last stage.
module jtag_in_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise_c,
    output logic [WIDTH-1:0] fall_c
);

    logic [STAGES-1:0][WIDTH-1:0] stg;
    logic [WIDTH-1:0]             prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg  <= '0;
            prev <= '0;
        end else begin
            stg  <= {stg[STAGES-2:0], d};
            prev <= stg[STAGES-1];
        end
    end

    assign q      = stg[STAGES-1];
    assign rise_c = stg[STAGES-1] & ~prev;
    assign fall_c = ~stg[STAGES-1] & prev;

endmodule

// File: rtl/jtag_user_dr.sv
// Multi-channel JTAG user DR engine: oversampled TAP tracking, per-channel capture/shift/update.
// Optional JTAG_DR_LEN_CHECK_EN: update only on exact DR_WIDTH-bit shifts, else pulse upd_len_err.
module jtag_user_dr
    import jtag_pkg::*;
#(
    parameter int unsigned NUM_CHAN    = 2,
    parameter int unsigned DR_WIDTH    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    jtag_user_dr_if.slave  bus
);

    localparam int unsigned CHAN_W = chan_w(NUM_CHAN);
    localparam int unsigned CNT_W  = $clog2(DR_WIDTH + 2);
    localparam int unsigned BUS_W  = NUM_CHAN + 3;

    logic                tck_rise_c, tck_fall_c, unused_tck_lvl;
    logic [BUS_W-1:0]    bus_s, unused_bus_rise, unused_bus_fall;
    logic                tms_s, tdi_s, reset_s;
    logic [NUM_CHAN-1:0] sel_s;

    jtag_in_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_tck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (bus.jtag_tck),
        .q      (unused_tck_lvl),
        .rise_c (tck_rise_c),
        .fall_c (tck_fall_c)
    );

    jtag_in_sync #(.WIDTH(BUS_W), .STAGES(SYNC_STAGES)) u_bus_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      ({bus.jtag_sel, bus.jtag_reset, bus.jtag_tdi, bus.jtag_tms}),
        .q      (bus_s),
        .rise_c (unused_bus_rise),
        .fall_c (unused_bus_fall)
    );

    assign tms_s   = bus_s[0];
    assign tdi_s   = bus_s[1];
    assign reset_s = bus_s[2];
    assign sel_s   = bus_s[BUS_W-1:3];

    tap_state_t          state, state_nxt;
    logic [DR_WIDTH-1:0] sr;
    logic [CNT_W-1:0]    cnt;
    logic                act_vld;
    logic [CHAN_W-1:0]   act_chan;
    logic                tdo;
    logic                upd_valid;
    logic [CHAN_W-1:0]   upd_chan;
    logic [DR_WIDTH-1:0] upd_data;
    logic                len_err;

    logic                sel_any_c;
    logic [CHAN_W-1:0]   sel_idx_c;
    logic [DR_WIDTH-1:0] cap_word_c;

    // Lowest selected chain wins; descending loop lets the lowest index assign last.
    always_comb begin
        sel_any_c  = 1'b0;
        sel_idx_c  = '0;
        cap_word_c = '0;
        for (int i = int'(NUM_CHAN) - 1; i >= 0; i--) begin
            if (sel_s[i]) begin
                sel_any_c  = 1'b1;
                sel_idx_c  = CHAN_W'(i);
                cap_word_c = bus.cap_data[i*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TEST_LOGIC_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (reset_s)         state_nxt = TEST_LOGIC_RESET;
        else if (tck_rise_c) state_nxt = tap_next(state, tms_s);
    end

    // DR datapath; acts on the current state before it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            act_vld   <= 1'b0;
            act_chan  <= '0;
            tdo       <= 1'b0;
            upd_valid <= 1'b0;
            upd_chan  <= '0;
            upd_data  <= '0;
            len_err   <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            len_err   <= 1'b0;
            if (tck_fall_c) tdo <= (state == SHIFT_DR && act_vld) ? sr[0] : 1'b0;
            if (reset_s || state == TEST_LOGIC_RESET) begin
                act_vld  <= 1'b0;
                act_chan <= '0;
                if (reset_s) begin
                    sr  <= '0;
                    cnt <= '0;
                end
            end else begin
                if (tck_rise_c && state == CAPTURE_DR) begin
                    act_vld  <= sel_any_c;
                    act_chan <= sel_idx_c;
                    cnt      <= '0;
                    if (sel_any_c) sr <= cap_word_c;
                end else if (tck_rise_c && state == SHIFT_DR && act_vld) begin
                    sr <= {tdi_s, sr[DR_WIDTH-1:1]};
                    if (cnt != CNT_W'(DR_WIDTH + 1)) cnt <= cnt + CNT_W'(1);
                end
                if (tck_fall_c && state == UPDATE_DR && act_vld) begin
`ifdef JTAG_DR_LEN_CHECK_EN
                    if (cnt == CNT_W'(DR_WIDTH)) begin
                        upd_valid <= 1'b1;
                        upd_chan  <= act_chan;
                        upd_data  <= sr;
                    end else begin
                        len_err <= 1'b1;
                    end
`else
                    upd_valid <= 1'b1;
                    upd_chan  <= act_chan;
                    upd_data  <= sr;
`endif
                end
            end
        end
    end

    assign bus.jtag_tdo  = tdo;
    assign bus.upd_valid = upd_valid;
    assign bus.upd_chan  = upd_chan;
    assign bus.upd_data  = upd_data;
`ifdef JTAG_DR_LEN_CHECK_EN
    assign bus.upd_len_err = len_err;
`else
    logic unused_len_err;
    assign unused_len_err = len_err;
`endif

endmodule
